// File: rtl/mgmt_wb_port_xbar.sv
// Management Wishbone port crossbar: routes one master onto NUM_PORTS
// address-decoded slave ports, one transaction at a time, with a slave-wait
// timeout that forces an error response and records timeout status.
module mgmt_wb_port_xbar #(
  parameter int                        NUM_PORTS   = 2,
  parameter logic [NUM_PORTS*32-1:0]   PORT_BASE   = {32'h2600_0000, 32'h3000_0000},
  parameter logic [NUM_PORTS*32-1:0]   PORT_MASK   = {32'hFF00_0000, 32'hF000_0000},
  parameter int                        TIMEOUT_CYC = 255,
  parameter logic [31:0]               ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      m_cyc_i,
  input  logic                      m_stb_i,
  input  logic                      m_we_i,
  input  logic [3:0]                m_sel_i,
  input  logic [31:0]               m_adr_i,
  input  logic [31:0]               m_dat_i,
  output logic                      m_ack_o,
  output logic                      m_err_o,
  output logic [31:0]               m_dat_o,
  output logic [NUM_PORTS-1:0]      s_cyc_o,
  output logic [NUM_PORTS-1:0]      s_stb_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  input  logic [NUM_PORTS-1:0]      s_ack_i,
  input  logic [NUM_PORTS*32-1:0]   s_dat_i,
  input  logic [NUM_PORTS-1:0]      port_iena,
  input  logic                      tmo_clr_i,
  output logic                      tmo_flag_o,
  output logic [2:0]                tmo_port_o,
  output logic [7:0]                tmo_cnt_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t                state;
  logic [2:0]            sel_idx;
  logic [15:0]           wait_cnt;
  logic [NUM_PORTS-1:0]  port_stb;

  logic                  match_any;
  logic [2:0]            match_idx;
  logic [NUM_PORTS-1:0]  match_oh;
  logic                  ack_hit;
  logic [31:0]           ack_dat;

  assign s_cyc_o = port_stb;
  assign s_stb_o = port_stb;

  // Address decode; scanning downward lets the lowest matching port win
  always_comb begin
    match_any = 1'b0;
    match_idx = 3'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((m_adr_i & PORT_MASK[i*32 +: 32]) == (PORT_BASE[i*32 +: 32] & PORT_MASK[i*32 +: 32])) begin
        match_any = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  // One-hot strobe pattern for the decoded port
  always_comb begin
    match_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      match_oh[i] = match_any && (match_idx == 3'(i));
    end
  end

  // Pick the selected port's ack (gated by its return enable) and read data
  always_comb begin
    ack_hit = 1'b0;
    ack_dat = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_idx == 3'(i)) begin
        ack_hit = s_ack_i[i] & port_iena[i];
        ack_dat = s_dat_i[i*32 +: 32];
      end
    end
  end

  // Transaction FSM with registered request, response and timeout status
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      sel_idx    <= 3'd0;
      wait_cnt   <= 16'd0;
      port_stb   <= '0;
      m_ack_o    <= 1'b0;
      m_err_o    <= 1'b0;
      m_dat_o    <= 32'd0;
      s_we_o     <= 1'b0;
      s_sel_o    <= 4'd0;
      s_adr_o    <= 32'd0;
      s_dat_o    <= 32'd0;
      tmo_flag_o <= 1'b0;
      tmo_port_o <= 3'd0;
      tmo_cnt_o  <= 8'd0;
    end else begin
      if (tmo_clr_i) begin
        tmo_flag_o <= 1'b0;
        tmo_cnt_o  <= 8'd0;
      end
      case (state)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            s_we_o  <= m_we_i;
            s_sel_o <= m_sel_i;
            s_adr_o <= m_adr_i;
            s_dat_o <= m_dat_i;
            sel_idx <= match_idx;
            if (match_any) begin
              port_stb <= match_oh;
              wait_cnt <= 16'd0;
              state    <= ACTIVE;
            end else begin
              m_ack_o <= 1'b1;
              m_err_o <= 1'b1;
              m_dat_o <= ERR_DATA;
              state   <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (!m_cyc_i) begin
            port_stb <= '0;
            state    <= IDLE;
          end else if (ack_hit) begin
            port_stb <= '0;
            m_ack_o  <= 1'b1;
            m_err_o  <= 1'b0;
            m_dat_o  <= ack_dat;
            state    <= RESP;
          end else if (wait_cnt == TMO_LAST) begin
            port_stb   <= '0;
            m_ack_o    <= 1'b1;
            m_err_o    <= 1'b1;
            m_dat_o    <= ERR_DATA;
            state      <= RESP;
            tmo_flag_o <= 1'b1;
            tmo_port_o <= sel_idx;
            if (tmo_clr_i) begin
              tmo_cnt_o <= 8'd1;
            end else if (tmo_cnt_o != 8'hFF) begin
              tmo_cnt_o <= tmo_cnt_o + 8'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          m_ack_o <= 1'b0;
          m_err_o <= 1'b0;
          m_dat_o <= 32'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mgmt_wb_port_xbar.md
MGMT_WB_PORT_XBAR -- requirements
Module: mgmt_wb_port_xbar

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of exported Wishbone ports (legal range 1..8).
REQ-002 Parameter PORT_BASE, default {32'h2600_0000, 32'h3000_0000}, NUM_PORTS*32 bits; port i base address in bits [32i+31:32i].
REQ-003 Parameter PORT_MASK, default {32'hFF00_0000, 32'hF000_0000}, NUM_PORTS*32 bits; port i address-compare mask.
REQ-004 Parameter TIMEOUT_CYC, default 255, slave-wait cycles before a forced error response (legal range 1..65535).
REQ-005 Parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on any error response.
REQ-006 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-007 wb_rst_i  in  1  reset; synchronous, active-high.
REQ-008 m_cyc_i, m_stb_i, m_we_i  in  1 each  management-master Wishbone request.
REQ-009 m_sel_i  in  4;  m_adr_i  in  32;  m_dat_i  in  32  master byte selects, address and write data.
REQ-010 m_ack_o  out  1;  m_err_o  out  1;  m_dat_o  out  32  master response.
REQ-011 s_cyc_o, s_stb_o  out  NUM_PORTS  per-port request strobes, one-hot or zero.
REQ-012 s_we_o  out  1;  s_sel_o  out  4;  s_adr_o  out  32;  s_dat_o  out  32  shared registered request fields.
REQ-013 s_ack_i  in  NUM_PORTS;  s_dat_i  in  NUM_PORTS*32  per-port slave responses.
REQ-014 port_iena  in  NUM_PORTS  per-port return enable; when low, that port's ack and data are ignored.
REQ-015 tmo_clr_i  in  1  clears the timeout status.
REQ-016 tmo_flag_o  out  1;  tmo_port_o  out  3;  tmo_cnt_o  out  8  timeout status.

Function
REQ-017 Port i matches when (m_adr_i & MASK_i) == (BASE_i & MASK_i); if several ports match, the lowest index is selected.
REQ-018 FSM states: IDLE, ACTIVE, RESP.
REQ-019 IDLE: when m_cyc_i & m_stb_i, latch we/sel/adr/dat and the selected index; go to ACTIVE if a port matches, else go to RESP with the error bit set.
REQ-020 ACTIVE: s_cyc_o[sel] and s_stb_o[sel] = 1; all other bits 0.
REQ-021 ACTIVE exit on ack: on s_ack_i[sel] & port_iena[sel], latch s_dat_i[sel] and go to RESP, error bit clear.
REQ-022 RESP: m_ack_o = 1 for exactly one cycle, then go to IDLE.
REQ-023 RESP data: m_dat_o = the latched data on success, ERR_DATA on error.
REQ-024 RESP error: m_err_o = m_ack_o & error bit.
REQ-025 Latency: a request sampled in IDLE at cycle T drives s_stb_o at T+1; a slave ack at cycle T+k gives m_ack_o at T+k+1; m_ack_o is 0 in IDLE and ACTIVE.
REQ-026 Wait counter: 16 bits; cleared on entry to ACTIVE; increments each ACTIVE cycle without a qualifying ack.
REQ-027 Timeout: when the counter equals TIMEOUT_CYC-1 and no ack is present, go to RESP with the error bit set, set tmo_flag_o, load tmo_port_o = sel, and increment tmo_cnt_o (saturates at 255).
REQ-028 Ack and timeout in the same cycle: the ack wins; no timeout is recorded.
REQ-029 Master abort: if m_cyc_i = 0 in ACTIVE, drop all s_cyc_o/s_stb_o next cycle and return to IDLE; no m_ack_o, no status change.
REQ-030 Decode error (no matching port): no s_stb_o is asserted and the timeout status is unaffected.
REQ-031 tmo_clr_i zeroes tmo_flag_o and tmo_cnt_o; if a timeout occurs in the same cycle, the result is flag = 1, cnt = 1, and tmo_port_o updated.
REQ-032 Only one transaction is outstanding at a time; master inputs are ignored outside IDLE except m_cyc_i for abort.

Reset
REQ-033 While wb_rst_i = 1 at a clock edge, the next state is IDLE and all outputs are 0.
REQ-034 Reset in ACTIVE or RESP discards the transaction: no m_ack_o is issued afterwards, and the counter and status are cleared.

Verification
REQ-035 Read to 0x3000_0010, port 0 acks after 3 cycles with 0x1234_5678 -> s_stb_o = 2'b01 at T+1; m_ack_o = 1 at T+4 with m_dat_o = 0x1234_5678, m_err_o = 0.
REQ-036 Write to 0x2600_0004, data 0xA5A5_A5A5, sel 4'b0011 -> s_stb_o = 2'b10, s_dat_o = 0xA5A5_A5A5, s_sel_o = 4'b0011; one m_ack_o.
REQ-037 Access to 0x1000_0000 -> m_ack_o = 1 and m_err_o = 1 at T+1, m_dat_o = 0xDEAD_BEEF, s_stb_o never asserted, tmo_cnt_o unchanged.
REQ-038 Port 0 never acks, TIMEOUT_CYC = 255 -> error response at T+256; tmo_flag_o = 1, tmo_port_o = 0, tmo_cnt_o = 1; port_iena[0] = 0 with s_ack_i[0] = 1 gives the same result.
REQ-039 m_cyc_i dropped 5 cycles into ACTIVE -> s_stb_o = 0 next cycle, no m_ack_o; wb_rst_i pulsed in ACTIVE -> all outputs 0, no later ack.
REQ-040 256 consecutive timeouts -> tmo_cnt_o = 255; tmo_clr_i coincident with a timeout -> tmo_cnt_o = 1, tmo_flag_o = 1.
